// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and data access (D).
// Define ARB_TIMEOUT_EN to abort a transaction after MAX_WAIT unacknowledged cycles and set a sticky bus_err.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          istall,
    output logic          dstall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t        r_state, w_next;
    logic          r_last_d;
    logic          r_mem_req, r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_rdata, r_dm_rdata;
    logic          r_if_ready, r_dm_ready;

    logic          w_i_elig, w_d_elig;
    logic          w_grant_i, w_grant_d;
    logic          w_busy, w_timeout, w_done;
    logic [DW-1:0] w_rdata;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must lie in 1..255 to fit the 8-bit wait counter");
    end

    // A requester whose ready is pulsing this cycle has just been served and sits out one grant.
    assign w_i_elig  = if_req & ~r_if_ready;
    assign w_d_elig  = dm_req & ~r_dm_ready;
    assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);
    assign w_grant_i = w_i_elig & (~w_d_elig |  r_last_d);

    assign w_busy  = (r_state != IDLE);
    assign w_done  = w_busy & (mem_ack | w_timeout);
    assign w_rdata = w_timeout ? '0 : mem_rdata;

    assign istall = w_i_elig;
    assign dstall = w_d_elig;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_bus_err;

    assign w_timeout = w_busy & ~mem_ack & (r_wait == 8'(MAX_WAIT - 1));
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wait    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (!w_busy)
                r_wait <= '0;
            else if (!mem_ack)
                r_wait <= r_wait + 8'd1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clrn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d)
                    w_next = DBUSY;
                else if (w_grant_i)
                    w_next = IBUSY;
            end
            IBUSY, DBUSY: begin
                if (w_done)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_last_d    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            if (r_state == IDLE) begin
                if (w_grant_d) begin
                    r_last_d    <= 1'b1;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                end else if (w_grant_i) begin
                    r_last_d    <= 1'b0;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                end
            end else if (w_done) begin
                // A requester that dropped its req (flush) still gets rdata but no ready pulse.
                r_mem_req <= 1'b0;
                if (r_state == IBUSY) begin
                    r_if_rdata <= w_rdata;
                    r_if_ready <= if_req;
                end else begin
                    r_dm_rdata <= w_rdata;
                    r_dm_ready <= dm_req;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;

endmodule
